// File: rtl/coherency_bus_ctrl_if.sv
// coherency_bus_ctrl_if
//   Bundles the per-core L1 request/response signals and the RAM port of the
//   snooping bus controller. Per-core buses are packed, core i at [i*32 +: 32].
//
//   master : the bus controller (drives waits, loads, snoop outputs, RAM strobes)
//   slave  : the caches and the RAM model (drive requests, snoop responses,
//            RAM read data and RAM status)
//
//   Cache side : iREN, iaddr, iwait, iload, dREN, dWEN, daddr, dstore,
//                ccwrite, cctrans, ccdirty, dwait, dload, ccwait, ccinv,
//                ccsnoopaddr
//   RAM side   : ramREN, ramWEN, ramaddr, ramstore, ramload,
//                ramstate (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
interface coherency_bus_ctrl_if #(
    parameter int NCPU = 2
) ();
    logic [NCPU-1:0]      iREN;
    logic [32*NCPU-1:0]   iaddr;
    logic [NCPU-1:0]      iwait;
    logic [32*NCPU-1:0]   iload;

    logic [NCPU-1:0]      dREN;
    logic [NCPU-1:0]      dWEN;
    logic [32*NCPU-1:0]   daddr;
    logic [32*NCPU-1:0]   dstore;
    logic [NCPU-1:0]      ccwrite;
    logic [NCPU-1:0]      cctrans;
    logic [NCPU-1:0]      ccdirty;
    logic [NCPU-1:0]      dwait;
    logic [32*NCPU-1:0]   dload;
    logic [NCPU-1:0]      ccwait;
    logic [NCPU-1:0]      ccinv;
    logic [32*NCPU-1:0]   ccsnoopaddr;

    logic                 ramREN;
    logic                 ramWEN;
    logic [31:0]          ramaddr;
    logic [31:0]          ramstore;
    logic [31:0]          ramload;
    logic [1:0]           ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
               ccwrite, cctrans, ccdirty, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
               ccwrite, cctrans, ccdirty, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherency_bus_ctrl.sv
// coherency_bus_ctrl
//   NCPU-way snooping bus controller between the per-core L1 caches and a
//   single-ported RAM. Arbitrates instruction fetches, data read misses,
//   write-backs and invalidate-only upgrades; every data miss is snooped in
//   all other caches and served cache-to-cache (with a concurrent RAM update
//   when the supplier asserts dWEN) or from RAM. One word per transaction.
//
//   Parameters : NCPU (2..8) cores, SNOOP_LAT (1..4) cycles spent in SNOOP.
//   Ports      : CLK  - clock, posedge
//                RST  - asynchronous reset, active high
//                bus  - coherency_bus_ctrl_if.master (cache and RAM signals)
module coherency_bus_ctrl #(
    parameter int NCPU      = 2,
    parameter int SNOOP_LAT = 1
) (
    input logic                  CLK,
    input logic                  RST,
    coherency_bus_ctrl_if.master bus
);
    localparam int          IW = $clog2(NCPU);
    localparam int          CW = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
    localparam int unsigned N  = NCPU;

    typedef logic [IW-1:0] idx_t;

    typedef enum logic [2:0] {
        IDLE, IFETCH, DWB, SNOOP, C2C, M2C, INV
    } state_t;

    typedef enum logic [1:0] {
        RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR
    } ram_state_t;

    state_t          state, state_n;
    idx_t            req, req_n;
    idx_t            sup, sup_n;
    logic [CW-1:0]   cnt, cnt_n;
    idx_t            dptr, dptr_n;
    idx_t            iptr, iptr_n;

    logic [NCPU-1:0] dreq;
    logic [NCPU-1:0] req_oh;
    logic [NCPU-1:0] dirty_m;
    idx_t            dirty_pick;
    idx_t            dgnt, ignt;
    logic            ram_done;

    logic [31:0]     iaddr_a  [NCPU];
    logic [31:0]     daddr_a  [NCPU];
    logic [31:0]     dstore_a [NCPU];
    logic [31:0]     iload_a  [NCPU];
    logic [31:0]     dload_a  [NCPU];
    logic [31:0]     snoop_a  [NCPU];

    for (genvar g = 0; g < NCPU; g++) begin : g_word
        assign iaddr_a[g]                  = bus.iaddr[g*32 +: 32];
        assign daddr_a[g]                  = bus.daddr[g*32 +: 32];
        assign dstore_a[g]                 = bus.dstore[g*32 +: 32];
        assign bus.iload[g*32 +: 32]       = iload_a[g];
        assign bus.dload[g*32 +: 32]       = dload_a[g];
        assign bus.ccsnoopaddr[g*32 +: 32] = snoop_a[g];
    end

    // Round-robin pick: scan offsets from lowest priority to highest so the
    // last hit written is the first requester at or after ptr.
    function automatic idx_t rr_pick(input logic [NCPU-1:0] vec, input idx_t ptr);
        idx_t        pick;
        int unsigned pos;
        pick = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + (N - 1 - k)) % N;
            if (vec[pos]) pick = idx_t'(pos);
        end
        return pick;
    endfunction

    function automatic idx_t next_idx(input idx_t i);
        return (i == idx_t'(N - 1)) ? '0 : i + idx_t'(1);
    endfunction

    assign dreq     = bus.dREN | bus.dWEN | bus.cctrans;
    assign dgnt     = rr_pick(dreq, dptr);
    assign ignt     = rr_pick(bus.iREN, iptr);
    assign ram_done = (bus.ramstate == RAM_ACCESS);
    assign dirty_m  = bus.ccdirty & ~req_oh;

    always_comb begin
        req_oh     = '0;
        dirty_pick = '0;
        for (int unsigned j = 0; j < N; j++) begin
            req_oh[j] = (idx_t'(j) == req);
        end
        // Lowest-index dirty responder supplies the line.
        for (int unsigned k = 0; k < N; k++) begin
            if (dirty_m[N - 1 - k]) dirty_pick = idx_t'(N - 1 - k);
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            req   <= '0;
            sup   <= '0;
            cnt   <= '0;
            dptr  <= '0;
            iptr  <= '0;
        end else begin
            state <= state_n;
            req   <= req_n;
            sup   <= sup_n;
            cnt   <= cnt_n;
            dptr  <= dptr_n;
            iptr  <= iptr_n;
        end
    end

    // Next-state logic; a dropped request strobe aborts without moving pointers.
    always_comb begin
        state_n = state;
        req_n   = req;
        sup_n   = sup;
        cnt_n   = cnt;
        dptr_n  = dptr;
        iptr_n  = iptr;
        case (state)
            IDLE: begin
                if (|dreq) begin
                    req_n = dgnt;
                    if (bus.dWEN[dgnt]) begin
                        state_n = DWB;
                    end else if (bus.dREN[dgnt]) begin
                        state_n = SNOOP;
                        cnt_n   = '0;
                    end else begin
                        state_n = INV;
                    end
                end else if (|bus.iREN) begin
                    req_n   = ignt;
                    state_n = IFETCH;
                end
            end
            IFETCH: begin
                if (!bus.iREN[req]) begin
                    state_n = IDLE;
                end else if (ram_done) begin
                    state_n = IDLE;
                    iptr_n  = next_idx(req);
                end
            end
            DWB: begin
                if (!bus.dWEN[req]) begin
                    state_n = IDLE;
                end else if (ram_done) begin
                    state_n = IDLE;
                    dptr_n  = next_idx(req);
                end
            end
            SNOOP: begin
                if (!bus.dREN[req]) begin
                    state_n = IDLE;
                end else if (cnt == CW'(SNOOP_LAT - 1)) begin
                    if (|dirty_m) begin
                        sup_n   = dirty_pick;
                        state_n = C2C;
                    end else begin
                        state_n = M2C;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            C2C: begin
                if (ram_done) begin
                    state_n = IDLE;
                    dptr_n  = next_idx(req);
                end
            end
            M2C: begin
                if (!bus.dREN[req]) begin
                    state_n = IDLE;
                end else if (ram_done) begin
                    state_n = IDLE;
                    dptr_n  = next_idx(req);
                end
            end
            INV: begin
                state_n = IDLE;
                dptr_n  = next_idx(req);
            end
            default: state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.ccwait   = '0;
        bus.ccinv    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        for (int unsigned j = 0; j < N; j++) begin
            iload_a[j] = '0;
            dload_a[j] = '0;
            snoop_a[j] = '0;
        end
        case (state)
            IFETCH: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = iaddr_a[req];
                iload_a[req] = bus.ramload;
                if (ram_done && bus.iREN[req]) bus.iwait[req] = 1'b0;
            end
            DWB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = daddr_a[req];
                bus.ramstore = dstore_a[req];
                if (ram_done && bus.dWEN[req]) bus.dwait[req] = 1'b0;
            end
            SNOOP: begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (!req_oh[j]) begin
                        bus.ccwait[j] = 1'b1;
                        bus.ccinv[j]  = bus.ccwrite[req];
                        snoop_a[j]    = daddr_a[req];
                    end
                end
            end
            C2C: begin
                // The supplier stays stalled so its dstore holds until the ack.
                bus.ccwait[sup] = 1'b1;
                dload_a[req]    = dstore_a[sup];
                bus.ramWEN      = bus.dWEN[sup];
                bus.ramaddr     = daddr_a[req];
                bus.ramstore    = dstore_a[sup];
                if (ram_done) begin
                    bus.dwait[req] = 1'b0;
                    bus.dwait[sup] = 1'b0;
                end
            end
            M2C: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = daddr_a[req];
                dload_a[req] = bus.ramload;
                if (ram_done && bus.dREN[req]) bus.dwait[req] = 1'b0;
            end
            INV: begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (!req_oh[j]) begin
                        bus.ccwait[j] = 1'b1;
                        bus.ccinv[j]  = 1'b1;
                        snoop_a[j]    = daddr_a[req];
                    end
                end
                bus.dwait[req] = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherency_bus_ctrl.sv
module tb_coherency_bus_ctrl;
    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic CLK = 1'b0;
    logic rst2 = 1'b1;
    logic rst4 = 1'b1;
    always #5 CLK = ~CLK;

    coherency_bus_ctrl_if #(.NCPU(2)) b2 ();
    coherency_bus_ctrl_if #(.NCPU(4)) b4 ();

    coherency_bus_ctrl #(.NCPU(2), .SNOOP_LAT(1)) dut2 (.CLK(CLK), .RST(rst2), .bus(b2));
    coherency_bus_ctrl #(.NCPU(4), .SNOOP_LAT(2)) dut4 (.CLK(CLK), .RST(rst4), .bus(b4));

    typedef struct {
        logic        rst;
        logic [1:0]  iren, dren, dwen, cctr, ccw, ccd, rs;
        logic [31:0] rl;
        logic [1:0]  e_iwait, e_dwait, e_ccwait, e_ccinv;
        logic        e_ren, e_wen;
        logic [31:0] e_raddr, e_rstore;
        logic [63:0] e_iload, e_dload, e_snoop;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic [1:0] iren, dren, dwen,
                                cctr, ccw, ccd, rs, input logic [31:0] rl);
        vec_t v;
        v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.cctr = cctr; v.ccw = ccw; v.ccd = ccd; v.rs = rs; v.rl = rl;
        v.e_iwait = 2'b11; v.e_dwait = 2'b11; v.e_ccwait = '0; v.e_ccinv = '0;
        v.e_ren = 1'b0; v.e_wen = 1'b0; v.e_raddr = '0; v.e_rstore = '0;
        v.e_iload = '0; v.e_dload = '0; v.e_snoop = '0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push();
        tbl.push_back(cur);
    endtask

    initial begin
        b2.iREN = '0; b2.dREN = '0; b2.dWEN = '0; b2.cctrans = '0;
        b2.ccwrite = '0; b2.ccdirty = '0; b2.ramload = '0; b2.ramstate = FREE;
        b2.iaddr  = {32'h200, 32'h100};
        b2.daddr  = {32'h60, 32'h40};
        b2.dstore = {32'hBBBB1111, 32'hAAAA0000};
        b4.iREN = '0; b4.dREN = '0; b4.dWEN = '0; b4.cctrans = '0;
        b4.ccwrite = '0; b4.ccdirty = '0; b4.ramload = '0; b4.ramstate = FREE;
        b4.iaddr  = '0;
        b4.daddr  = {32'h30, 32'h80, 32'h10, 32'h00};
        b4.dstore = {32'hF3, 32'hF2, 32'h1234, 32'hF0};

        // ---- NCPU=2, SNOOP_LAT=1 vector table (one entry per cycle) ----
        cur = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE, 32'h0); push();          // v0 reset
        // fetch contention
        cur = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h11); push();          // v1 IDLE
        cur = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h11);
        cur.e_iwait = 2'b10; cur.e_ren = 1; cur.e_raddr = 32'h100; cur.e_iload = {32'h0, 32'h11}; push();
        cur = mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h22); push();          // v3 IDLE
        cur = mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h22);
        cur.e_iwait = 2'b01; cur.e_ren = 1; cur.e_raddr = 32'h200; cur.e_iload = {32'h22, 32'h0}; push();
        cur = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h0); push();           // v5
        // clean miss core 0
        cur = mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'hCAFE); push();        // v6 IDLE
        cur = mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'hCAFE);
        cur.e_ccwait = 2'b10; cur.e_snoop = {32'h40, 32'h0}; push();                          // v7 SNOOP
        cur = mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'hCAFE);
        cur.e_ren = 1; cur.e_raddr = 32'h40; cur.e_dload = {32'h0, 32'hCAFE}; cur.e_dwait = 2'b10; push();
        // write-back core 1 (dptr=1), leaves dptr=0
        cur = mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, ACC, 32'h0); push();           // v9 IDLE
        cur = mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, ACC, 32'h0);
        cur.e_wen = 1; cur.e_raddr = 32'h60; cur.e_rstore = 32'hBBBB1111; cur.e_dwait = 2'b01; push();
        // upgrade core 0 vs write-back core 1, dptr=0
        cur = mk(0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, ACC, 32'h0); push();           // v11 IDLE
        cur = mk(0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, ACC, 32'h0);
        cur.e_ccinv = 2'b10; cur.e_ccwait = 2'b10; cur.e_snoop = {32'h40, 32'h0}; cur.e_dwait = 2'b10; push();
        cur = mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, ACC, 32'h0); push();           // v13 IDLE
        // DWB stall: BUSY x3, ERROR, ACCESS
        for (int k = 0; k < 5; k++) begin
            cur = mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00,
                     (k < 3) ? BUSY : ((k == 3) ? ERR : ACC), 32'h0);
            cur.e_wen = 1; cur.e_raddr = 32'h60; cur.e_rstore = 32'hBBBB1111;
            if (k == 4) cur.e_dwait = 2'b01;
            push();                                                                           // v14..v18
        end
        cur = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h0); push();           // v19
        // fetch core 1 with FREE, then abort
        cur = mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE, 32'h77); push();         // v20 IDLE
        cur = mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, FREE, 32'h77);
        cur.e_ren = 1; cur.e_raddr = 32'h200; cur.e_iload = {32'h77, 32'h0}; push();
        cur = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h77);
        cur.e_ren = 1; cur.e_raddr = 32'h200; cur.e_iload = {32'h77, 32'h0}; push();         // v22 abort
        cur = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h0); push();           // v23
        // data beats fetch; dirty core 1 supplies (C2C) with ccwrite
        cur = mk(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, ACC, 32'h55); push();          // v24 IDLE
        cur = mk(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, ACC, 32'h55);
        cur.e_ccwait = 2'b10; cur.e_ccinv = 2'b10; cur.e_snoop = {32'h40, 32'h0}; push();    // v25 SNOOP
        cur = mk(0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, ACC, 32'h55);
        cur.e_ccwait = 2'b10; cur.e_dload = {32'h0, 32'hBBBB1111}; cur.e_wen = 1;
        cur.e_raddr = 32'h40; cur.e_rstore = 32'hBBBB1111; cur.e_dwait = 2'b00; push();      // v26 C2C
        cur = mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h55); push();          // v27 IDLE
        cur = mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h55);
        cur.e_ren = 1; cur.e_raddr = 32'h200; cur.e_iload = {32'h55, 32'h0}; cur.e_iwait = 2'b01; push();
        cur = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h0); push();           // v29
        // miss core 1, reset mid-M2C
        cur = mk(0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, BUSY, 32'h99); push();         // v30 IDLE
        cur = mk(0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, BUSY, 32'h99);
        cur.e_ccwait = 2'b01; cur.e_snoop = {32'h0, 32'h60}; push();                          // v31 SNOOP
        cur = mk(0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, BUSY, 32'h99);
        cur.e_ren = 1; cur.e_raddr = 32'h60; cur.e_dload = {32'h99, 32'h0}; push();          // v32 M2C
        cur = mk(1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, BUSY, 32'h99); push();         // v33 reset
        cur = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h99); push();          // v34
        // both cores miss: dptr back to 0 after reset, then core 1 at dptr=1
        cur = mk(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h99); push();          // v35 IDLE
        cur = mk(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h99);
        cur.e_ccwait = 2'b10; cur.e_snoop = {32'h40, 32'h0}; push();                          // v36 SNOOP
        cur = mk(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h99);
        cur.e_ren = 1; cur.e_raddr = 32'h40; cur.e_dload = {32'h0, 32'h99}; cur.e_dwait = 2'b10; push();
        cur = mk(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h99); push();          // v38 IDLE
        cur = mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h99);
        cur.e_ccwait = 2'b01; cur.e_snoop = {32'h0, 32'h60}; push();                          // v39 SNOOP abort
        cur = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ACC, 32'h99); push();          // v40 IDLE

        foreach (tbl[i]) begin
            @(posedge CLK); #2;
            rst2 = tbl[i].rst;
            b2.iREN = tbl[i].iren; b2.dREN = tbl[i].dren; b2.dWEN = tbl[i].dwen;
            b2.cctrans = tbl[i].cctr; b2.ccwrite = tbl[i].ccw; b2.ccdirty = tbl[i].ccd;
            b2.ramstate = tbl[i].rs; b2.ramload = tbl[i].rl;
            @(negedge CLK);
            chk($sformatf("v%0d.ctl", i),
                {b2.iwait, b2.dwait, b2.ccwait, b2.ccinv, b2.ramREN, b2.ramWEN},
                {tbl[i].e_iwait, tbl[i].e_dwait, tbl[i].e_ccwait, tbl[i].e_ccinv,
                 tbl[i].e_ren, tbl[i].e_wen});
            chk($sformatf("v%0d.ram", i), {b2.ramaddr, b2.ramstore},
                {tbl[i].e_raddr, tbl[i].e_rstore});
            chk($sformatf("v%0d.data", i), {b2.iload, b2.dload, b2.ccsnoopaddr},
                {tbl[i].e_iload, tbl[i].e_dload, tbl[i].e_snoop});
        end

        // ---- NCPU=4, SNOOP_LAT=2: dirty C2C with read-exclusive ----
        @(posedge CLK); #2;
        rst4 = 1'b0;
        b4.dREN = 4'b0100; b4.ccwrite = 4'b0100; b4.ccdirty = 4'b1110; b4.ramstate = ACC;
        @(negedge CLK);
        chk("c2c.idle.ctl", {b4.iwait, b4.dwait, b4.ccwait, b4.ccinv, b4.ramREN, b4.ramWEN},
            {4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0});
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #2;
            @(negedge CLK);
            chk($sformatf("c2c.snoop%0d.ctl", k),
                {b4.iwait, b4.dwait, b4.ccwait, b4.ccinv, b4.ramREN, b4.ramWEN},
                {4'hF, 4'hF, 4'b1011, 4'b1011, 1'b0, 1'b0});
            chk($sformatf("c2c.snoop%0d.addr", k), b4.ccsnoopaddr,
                {32'h80, 32'h0, 32'h80, 32'h80});
        end
        @(posedge CLK); #2;
        b4.dWEN = 4'b0010;
        @(negedge CLK);
        chk("c2c.xfer.ctl", {b4.iwait, b4.dwait, b4.ccwait, b4.ccinv, b4.ramREN, b4.ramWEN},
            {4'hF, 4'b1001, 4'b0010, 4'h0, 1'b0, 1'b1});
        chk("c2c.xfer.ram", {b4.ramaddr, b4.ramstore}, {32'h80, 32'h1234});
        chk("c2c.xfer.dload", b4.dload, {32'h0, 32'h1234, 32'h0, 32'h0});
        @(posedge CLK); #2;
        b4.dREN = '0; b4.dWEN = '0; b4.ccwrite = '0; b4.ccdirty = '0;
        @(negedge CLK);
        chk("c2c.done.ctl", {b4.iwait, b4.dwait, b4.ccwait, b4.ccinv, b4.ramREN, b4.ramWEN},
            {4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
